// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control unit for the load/store/R/I datapath.
// Instructions are pre-decoded at the handshake so every control output leaves a flop.
module mips_multicycle_ctrl #(
   parameter int N       = 32,
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               instr_valid,
   input  logic [N-1:0]       instruction,
   output logic               instr_ready,
   output logic [N-1:0]       ir,
   output logic [3:0]         ALU_OP,
   output logic               RegWrite,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               MemtoReg,
   output logic               ALUSrc,
   output logic               RegDst,
   output logic               done,
   output logic               illegal,
   output logic [COUNT_W-1:0] retired
);

   // state    | meaning
   // S_IDLE   | ready for a new instruction, all controls low
   // S_DECODE | ir latched, illegal flagged here, controls low
   // S_EXEC   | ALU_OP/ALUSrc/RegDst/MemtoReg valid
   // S_MEM    | data-memory access (lw read, sw write + done)
   // S_WB     | register write-back + done
   typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
   typedef enum logic [2:0] {C_R, C_I, C_LW, C_SW, C_ILL} cls_t;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   state_t               state_q;
   cls_t                 cls_q, cls_d;
   logic [3:0]           alu_q, alu_d;
   logic                 dst_zero_q, dst_zero_d;
   logic [N-1:0]         ir_q;
   logic                 ready_q, regwrite_q, memread_q, memwrite_q;
   logic                 memtoreg_q, alusrc_q, regdst_q, done_q, illegal_q;
   logic [3:0]           alu_op_q;
   logic [COUNT_W-1:0]   retired_q;

   always_comb begin
      cls_d      = C_ILL;
      alu_d      = ALU_ADD;
      dst_zero_d = 1'b0;
      case (instruction[31:26])
         6'b000000: begin
            dst_zero_d = (instruction[15:11] == 5'd0);
            cls_d      = C_R;
            case (instruction[5:0])
               6'b100000: alu_d = ALU_ADD;
               6'b100010: alu_d = ALU_SUB;
               6'b100100: alu_d = ALU_AND;
               6'b100101: alu_d = ALU_OR;
               6'b101010: alu_d = ALU_SLT;
               default:   cls_d = C_ILL;
            endcase
         end
         6'b001000: begin cls_d = C_I;  alu_d = ALU_ADD; dst_zero_d = (instruction[20:16] == 5'd0); end
         6'b001100: begin cls_d = C_I;  alu_d = ALU_AND; dst_zero_d = (instruction[20:16] == 5'd0); end
         6'b001101: begin cls_d = C_I;  alu_d = ALU_OR;  dst_zero_d = (instruction[20:16] == 5'd0); end
         6'b100011: begin cls_d = C_LW; alu_d = ALU_ADD; dst_zero_d = (instruction[20:16] == 5'd0); end
         6'b101011: begin cls_d = C_SW; alu_d = ALU_ADD; end
         default:   cls_d = C_ILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cls_q      <= C_ILL;
         alu_q      <= 4'b0000;
         dst_zero_q <= 1'b0;
         ir_q       <= '0;
         ready_q    <= 1'b1;
         alu_op_q   <= 4'b0000;
         regwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         alusrc_q   <= 1'b0;
         regdst_q   <= 1'b0;
         done_q     <= 1'b0;
         illegal_q  <= 1'b0;
         retired_q  <= '0;
      end else begin
         done_q     <= 1'b0;
         illegal_q  <= 1'b0;
         regwrite_q <= 1'b0;
         memwrite_q <= 1'b0;
         if (done_q)
            retired_q <= retired_q + {{(COUNT_W-1){1'b0}}, 1'b1};
         case (state_q)
            S_IDLE: begin
               if (instr_valid) begin
                  ir_q       <= instruction;
                  cls_q      <= cls_d;
                  alu_q      <= alu_d;
                  dst_zero_q <= dst_zero_d;
                  illegal_q  <= (cls_d == C_ILL);
                  ready_q    <= 1'b0;
                  state_q    <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (cls_q == C_ILL) begin
                  ready_q <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  alu_op_q   <= alu_q;
                  alusrc_q   <= (cls_q != C_R);
                  regdst_q   <= (cls_q == C_R);
                  memtoreg_q <= (cls_q == C_LW);
                  state_q    <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (cls_q == C_LW || cls_q == C_SW) begin
                  memread_q  <= (cls_q == C_LW);
                  memwrite_q <= (cls_q == C_SW);
                  done_q     <= (cls_q == C_SW);
                  state_q    <= S_MEM;
               end else begin
                  regwrite_q <= !dst_zero_q;
                  done_q     <= 1'b1;
                  state_q    <= S_WB;
               end
            end
            S_MEM: begin
               if (cls_q == C_LW) begin
                  regwrite_q <= !dst_zero_q;
                  done_q     <= 1'b1;
                  state_q    <= S_WB;
               end else begin
                  alu_op_q   <= 4'b0000;
                  alusrc_q   <= 1'b0;
                  regdst_q   <= 1'b0;
                  memtoreg_q <= 1'b0;
                  memread_q  <= 1'b0;
                  ready_q    <= 1'b1;
                  state_q    <= S_IDLE;
               end
            end
            default: begin
               alu_op_q   <= 4'b0000;
               alusrc_q   <= 1'b0;
               regdst_q   <= 1'b0;
               memtoreg_q <= 1'b0;
               memread_q  <= 1'b0;
               ready_q    <= 1'b1;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

   assign instr_ready = ready_q;
   assign ir          = ir_q;
   assign ALU_OP      = alu_op_q;
   assign RegWrite    = regwrite_q;
   assign MemRead     = memread_q;
   assign MemWrite    = memwrite_q;
   assign MemtoReg    = memtoreg_q;
   assign ALUSrc      = alusrc_q;
   assign RegDst      = regdst_q;
   assign done        = done_q;
   assign illegal     = illegal_q;
   assign retired     = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl with a 2-bit retired counter so wrap is reachable.
module tb_mips_multicycle_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic [31:0] instruction;
   logic        instr_ready;
   logic [31:0] ir;
   logic [3:0]  ALU_OP;
   logic        RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, done, illegal;
   logic [1:0]  retired;

   int n_checks = 0;
   int n_fail   = 0;
   logic [1:0]  exp_ret = 2'd0;

   // {ready, ALU_OP[3:0], RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, done, illegal}
   logic [12:0] cap [1:5];
   logic [1:0]  cap_ret [1:5];
   logic [31:0] cap_ir [1:5];

   localparam logic [12:0] V_IDLE = 13'b1_0000_00000000;
   localparam logic [12:0] V_ZERO = 13'b0_0000_00000000;

   mips_multicycle_ctrl #(.N(32), .COUNT_W(2)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction(instruction),
      .instr_ready(instr_ready), .ir(ir), .ALU_OP(ALU_OP), .RegWrite(RegWrite),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .ALUSrc(ALUSrc),
      .RegDst(RegDst), .done(done), .illegal(illegal), .retired(retired)
   );

   always #5 clk = ~clk;

   function automatic logic [12:0] outv();
      return {instr_ready, ALU_OP, RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, done, illegal};
   endfunction

   // Called at a negedge; handshakes, then samples ncyc cycles at successive negedges.
   task automatic issue(input logic [31:0] ins, input int ncyc);
      int guard = 0;
      while (!instr_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!instr_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL handshake_wait: instr_ready got %b required 1", instr_ready);
      end
      instr_valid = 1'b1;
      instruction = ins;
      @(posedge clk);
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         if (k == 1) begin
            instr_valid = 1'b0;
            instruction = 32'hDEADBEEF;
         end
         cap[k]     = outv();
         cap_ret[k] = retired;
         cap_ir[k]  = ir;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      instr_valid = 1'b0;
      instruction = 32'h0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (outv() !== V_IDLE || retired !== 2'd0 || ir !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_state: got %b ret %0d ir %h required %b ret 0 ir 0", outv(), retired, ir, V_IDLE);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_add();
      logic [12:0] e [1:4];
      e[1] = V_ZERO;
      e[2] = 13'b0_0010_00000100;
      e[3] = 13'b0_0010_10000110;
      e[4] = V_IDLE;
      issue(32'h00018020, 4);
      exp_ret = exp_ret + 2'd1;
      for (int k = 1; k <= 4; k++) begin
         n_checks++;
         if (cap[k] !== e[k]) begin
            n_fail++;
            $display("FAIL add_cycle%0d: got %b required %b", k, cap[k], e[k]);
         end
      end
      n_checks++;
      if (cap_ir[2] !== 32'h00018020) begin
         n_fail++;
         $display("FAIL add_ir_held: got %h required 00018020", cap_ir[2]);
      end
      n_checks++;
      if (cap_ret[4] !== exp_ret) begin
         n_fail++;
         $display("FAIL add_retired: got %0d required %0d", cap_ret[4], exp_ret);
      end
   endtask

   task automatic test_lw();
      logic [12:0] e [1:5];
      e[1] = V_ZERO;
      e[2] = 13'b0_0010_00011000;
      e[3] = 13'b0_0010_01011000;
      e[4] = 13'b0_0010_11011010;
      e[5] = V_IDLE;
      issue(32'h8C410001, 5);
      exp_ret = exp_ret + 2'd1;
      for (int k = 1; k <= 5; k++) begin
         n_checks++;
         if (cap[k] !== e[k]) begin
            n_fail++;
            $display("FAIL lw_cycle%0d: got %b required %b", k, cap[k], e[k]);
         end
      end
      n_checks++;
      if (cap_ret[5] !== exp_ret) begin
         n_fail++;
         $display("FAIL lw_retired: got %0d required %0d", cap_ret[5], exp_ret);
      end
   endtask

   task automatic test_sw();
      logic [12:0] e [1:4];
      e[1] = V_ZERO;
      e[2] = 13'b0_0010_00001000;
      e[3] = 13'b0_0010_00101010;
      e[4] = V_IDLE;
      issue(32'hACA50002, 4);
      exp_ret = exp_ret + 2'd1;
      for (int k = 1; k <= 4; k++) begin
         n_checks++;
         if (cap[k] !== e[k]) begin
            n_fail++;
            $display("FAIL sw_cycle%0d: got %b required %b", k, cap[k], e[k]);
         end
      end
      n_checks++;
      if (cap_ret[4] !== exp_ret) begin
         n_fail++;
         $display("FAIL sw_retired: got %0d required %0d", cap_ret[4], exp_ret);
      end
   endtask

   task automatic test_illegal();
      issue(32'hFC000000, 2);
      n_checks++;
      if (cap[1] !== 13'b0_0000_00000001) begin
         n_fail++;
         $display("FAIL illegal_decode: got %b required 0000000000001", cap[1]);
      end
      n_checks++;
      if (cap[2] !== V_IDLE || cap_ret[2] !== exp_ret) begin
         n_fail++;
         $display("FAIL illegal_return: got %b ret %0d required %b ret %0d", cap[2], cap_ret[2], V_IDLE, exp_ret);
      end
   endtask

   task automatic test_r0_dest();
      logic [12:0] e [1:4];
      e[1] = V_ZERO;
      e[2] = 13'b0_0010_00001000;
      e[3] = 13'b0_0010_00001010;
      e[4] = V_IDLE;
      issue(32'h20000005, 4);
      exp_ret = exp_ret + 2'd1;
      for (int k = 1; k <= 4; k++) begin
         n_checks++;
         if (cap[k] !== e[k]) begin
            n_fail++;
            $display("FAIL addi_r0_cycle%0d: got %b required %b", k, cap[k], e[k]);
         end
      end
      n_checks++;
      if (cap_ret[4] !== exp_ret) begin
         n_fail++;
         $display("FAIL addi_r0_retired: got %0d required %0d", cap_ret[4], exp_ret);
      end
   endtask

   task automatic test_alu_ops();
      logic [31:0] ins [0:5];
      logic [3:0]  op  [0:5];
      logic        rdst [0:5];
      ins[0] = 32'h00221822; op[0] = 4'b0110; rdst[0] = 1'b1;
      ins[1] = 32'h00221824; op[1] = 4'b0000; rdst[1] = 1'b1;
      ins[2] = 32'h00221825; op[2] = 4'b0001; rdst[2] = 1'b1;
      ins[3] = 32'h0022182A; op[3] = 4'b0111; rdst[3] = 1'b1;
      ins[4] = 32'h30230007; op[4] = 4'b0000; rdst[4] = 1'b0;
      ins[5] = 32'h34230007; op[5] = 4'b0001; rdst[5] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         issue(ins[i], 4);
         exp_ret = exp_ret + 2'd1;
         n_checks++;
         if (cap[2][11:8] !== op[i] || cap[2][2] !== rdst[i] || cap[2][3] !== !rdst[i]
             || cap[3][7] !== 1'b1 || cap_ret[4] !== exp_ret) begin
            n_fail++;
            $display("FAIL alu_op_%h: exec %b wb %b ret %0d required alu %b regdst %b ret %0d",
                     ins[i], cap[2], cap[3], cap_ret[4], op[i], rdst[i], exp_ret);
         end
      end
      issue(32'h00221821, 2);
      n_checks++;
      if (cap[1] !== 13'b0_0000_00000001 || cap[2] !== V_IDLE) begin
         n_fail++;
         $display("FAIL bad_funct: got %b then %b required illegal pulse then idle", cap[1], cap[2]);
      end
   endtask

   task automatic test_reset_mid();
      issue(32'h00018020, 2);
      n_checks++;
      if (cap[2] !== 13'b0_0010_00000100) begin
         n_fail++;
         $display("FAIL midrst_exec: got %b required 0001000000100", cap[2]);
      end
      rst = 1'b0;
      #1;
      exp_ret = 2'd0;
      n_checks++;
      if (outv() !== V_IDLE || retired !== 2'd0) begin
         n_fail++;
         $display("FAIL midrst_abort: got %b ret %0d required %b ret 0", outv(), retired, V_IDLE);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (RegWrite !== 1'b0 || done !== 1'b0 || retired !== 2'd0) begin
         n_fail++;
         $display("FAIL midrst_noglitch: rw %b done %b ret %0d required 0 0 0", RegWrite, done, retired);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [31:0] ins [0:3];
      int          nc  [0:3];
      ins[0] = 32'h00018020; nc[0] = 4;
      ins[1] = 32'h8C410001; nc[1] = 5;
      ins[2] = 32'hACA50002; nc[2] = 4;
      ins[3] = 32'h20000005; nc[3] = 4;
      for (int i = 0; i < 4; i++) begin
         issue(ins[i], nc[i]);
         exp_ret = exp_ret + 2'd1;
         n_checks++;
         if (cap[nc[i]-1][1] !== 1'b1 || cap[nc[i]] !== V_IDLE || cap_ret[nc[i]] !== exp_ret) begin
            n_fail++;
            $display("FAIL b2b_%0d: done-cycle %b idle %b ret %0d required done, idle, ret %0d",
                     i, cap[nc[i]-1], cap[nc[i]], cap_ret[nc[i]], exp_ret);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw();
      test_sw();
      test_illegal();
      test_r0_dest();
      test_alu_ops();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
